rate_limiter_mc: RTL and testbench
==================================

# rate_limiter_mc

Multi-channel, parametrised slew-rate limiter: each of CHANNELS outputs moves toward its own programmable target by at most a programmable step per update tick. It succeeds the single-channel 6-bit limiter. It adds separate rise and fall steps, a runtime update prescaler, optional two's-complement data, and per-channel settled flags. It sits between the control/register interface and downstream actuators or DACs that must not see step changes.

## Interface
Parameters:
- WIDTH, 6, data width per channel
- STEP_W, 3, width of rise/fall step inputs
- CHANNELS, 4, number of independent channels (need not be a power of 2)
- DIV_W, 8, width of prescaler divide input
- SIGNED, 0, 1 = data and targets are two's complement; 0 = unsigned

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  target write strobe
- wr_ch  in  max(1,$clog2(CHANNELS))  channel index for write
- wr_data  in  WIDTH  new target value
- step_rise  in  STEP_W  max increase per tick (all channels)
- step_fall  in  STEP_W  max decrease per tick (all channels)
- div  in  DIV_W  tick period minus 1 (0 = every cycle)
- data_out  out  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH], registered
- settled  out  CHANNELS  bit i = 1 when data_out[i] == target[i]
- busy  out  1  OR-reduction of ~settled

## Operation
- Per channel: target register tgt[i] and output register out[i].
- Write: on a clk edge with wr_en=1 and wr_ch < CHANNELS, tgt[wr_ch] <= wr_data. wr_ch >= CHANNELS is ignored, with no state change.
- Prescaler: counter cnt counts 0..div and wraps to 0. tick = (cnt == div). If div is lowered below cnt, cnt counts up through wrap (2^DIV_W) and then resumes. No special-casing.
- On a tick edge, for every channel, compare against the tgt value held before that edge:
  - out < tgt: out += min(step_rise, tgt − out)
  - out > tgt: out −= min(step_fall, out − tgt)
  - equal: hold
- Never overshoots. Arithmetic is done at WIDTH+1 bits, so no wrap-around at range extremes.
- Comparison is signed when SIGNED=1 and unsigned otherwise. Steps are always unsigned.
- step = 0 in the required direction: channel freezes and settled[i] stays 0.
- Write and tick on the same edge, same channel: the tick uses the old target and the new target applies from the next tick. The output is never reset by a write.
- settled and busy are combinational from the tgt/out registers.

## Timing
- Reset (reset_n=0, asynchronous): out[*]=0, tgt[*]=0, cnt=0, so settled = all ones and busy = 0. Release takes effect on the first clk edge after reset_n rises.
- Reset mid-slew: outputs clear immediately, with no further steps.
- Write latency: settled[i] drops in the cycle after the write edge. The first step occurs at the next tick edge after that.
- Each tick takes |tgt − out| down by a step until equal. Slew duration is ceil(|Δ|/step) ticks, with each tick lasting (div+1) cycles.
- With div=0, data_out changes every cycle while slewing.

## Structure
- Shared package rate_limiter_pkg:
  - default WIDTH/STEP_W/DIV_W constants
  - helper for the wr_ch width (max(1, clog2))
- Sub-module rate_limiter_lane: one channel's tgt/out registers, compare, and clamp-step datapath, with a tick input.
  - Generated CHANNELS times.
  - The top holds the prescaler, write decode and busy reduction.

## Test plan
Defaults unless noted: WIDTH=6, STEP_W=3, CHANNELS=4, SIGNED=0, div=0.
- Reset:
  - Stimulus: hold reset_n=0, then pulse reset_n low asynchronously between edges.
  - Required: data_out=0 with no clock edge needed; settled=4'hF; busy=0.
- Rise:
  - Stimulus: write ch0=32 with step_rise=7.
  - Required: ch0 reads 7, 14, 21, 28, 32 on successive cycles; settled[0] returns to 1 at 32; other channels stay 0 and settled.
- Fall:
  - Stimulus: ch0 at 32; write 15 with step_fall=5.
  - Required: 27, 22, 17, 15, with no undershoot.
- Prescaler and freeze:
  - Stimulus A: div=3, write ch2=9, step_rise=4.
  - Required A: 4, 8, 9, each change exactly 4 cycles apart.
  - Stimulus B: step_rise=0.
  - Required B: ch2 holds and busy stays 1.
- Signed:
  - Stimulus: SIGNED=1, write ch1=−10 (6'h36) with step_fall=4.
  - Required: 0, −4, −8, −10. Also, from −32, target 31 with step_rise=7 never wraps.
- Edge cases:
  - Stimulus A: CHANNELS=3, wr_ch=3.
  - Required A: ignored.
  - Stimulus B: write ch0 on a tick edge mid-slew.
  - Required B: that step uses the old target; the new target is used from the next tick.
  - Stimulus C: assert reset_n mid-slew.
  - Required C: all clear to 0 immediately.

Source files
------------

// File: rtl/rate_limiter_pkg.sv
// rate_limiter_pkg: shared defaults and write-index width helper for the slew limiter
package rate_limiter_pkg;
  localparam int WIDTH_DEF = 6;
  localparam int STEP_W_DEF = 3;
  localparam int DIV_W_DEF = 8;
  localparam int CHANNELS_DEF = 4;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rate_limiter_lane.sv
// rate_limiter_lane: one channel's target/output registers and clamped step toward target
module rate_limiter_lane
  import rate_limiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              wr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [STEP_W-1:0] step_rise,
  input  logic [STEP_W-1:0] step_fall,
  output logic [WIDTH-1:0]  out,
  output logic              settled
);
  localparam int AW = (WIDTH > STEP_W ? WIDTH : STEP_W) + 1;
  logic [WIDTH-1:0] tgt, nxt;
  logic signed [AW-1:0] t_x, o_x, d, rs, fs;
  always_comb begin
    t_x = SIGNED ? AW'(signed'(tgt)) : AW'(tgt);
    o_x = SIGNED ? AW'(signed'(out)) : AW'(out);
    rs = AW'(step_rise);
    fs = AW'(step_fall);
    d = t_x - o_x;
    nxt = WIDTH'(d > 0 ? o_x + (rs < d ? rs : d) : d < 0 ? o_x - (fs < -d ? fs : -d) : o_x);
  end
  assign settled = out == tgt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt <= '0;
      out <= '0;
    end else begin
      if (wr) tgt <= wr_data;
      if (tick) out <= nxt;
    end
  end
endmodule

// File: rtl/rate_limiter_mc.sv
// rate_limiter_mc: multi-channel slew-rate limiter with shared prescaler and write decode
module rate_limiter_mc
  import rate_limiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [ch_w(CHANNELS)-1:0]     wr_ch,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [STEP_W-1:0]             step_rise,
  input  logic [STEP_W-1:0]             step_fall,
  input  logic [DIV_W-1:0]              div,
  output logic [CHANNELS*WIDTH-1:0]     data_out,
  output logic [CHANNELS-1:0]           settled,
  output logic                          busy
);
  logic [DIV_W-1:0] cnt;
  logic tick;
  assign tick = cnt == div;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    rate_limiter_lane #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SIGNED(SIGNED)) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .wr(wr_en && int'(wr_ch) == i),
      .wr_data(wr_data),
      .step_rise(step_rise),
      .step_fall(step_fall),
      .out(data_out[i*WIDTH +: WIDTH]),
      .settled(settled[i])
    );
  end
  assign busy = ~&settled;
endmodule

// File: tb/tb_rate_limiter_mc.sv
// tb_rate_limiter_mc: vector table, corner sequences and randomized model check of three limiter configurations
module tb_rate_limiter_mc;
  logic clk = 0, reset_n = 0, wr_en = 0;
  logic [1:0] wr_ch = 0;
  logic [5:0] wr_data = 0;
  logic [2:0] step_rise = 0, step_fall = 0;
  logic [7:0] div = 0;
  logic [23:0] do0, do1;
  logic [17:0] do2;
  logic [3:0] set0, set1;
  logic [2:0] set2;
  logic busy0, busy1, busy2;
  int n_chk = 0, n_fail = 0;
  int m_out[3][4], m_tgt[3][4];
  int m_cnt;
  typedef struct {
    logic wr_en;
    logic [1:0] wr_ch;
    logic [5:0] wr_data;
    logic [5:0] exp0;
    logic [3:0] exp_set;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  rate_limiter_mc u_dut (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .step_rise(step_rise), .step_fall(step_fall), .div(div), .data_out(do0), .settled(set0), .busy(busy0));
  rate_limiter_mc #(.SIGNED(1'b1)) u_sdut (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .step_rise(step_rise), .step_fall(step_fall), .div(div), .data_out(do1),
    .settled(set1), .busy(busy1));
  rate_limiter_mc #(.CHANNELS(3)) u_c3 (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .step_rise(step_rise), .step_fall(step_fall), .div(div), .data_out(do2),
    .settled(set2), .busy(busy2));

  function automatic int nch(input int k);
    return k == 2 ? 3 : 4;
  endfunction

  function automatic int sx(input int k, input logic [5:0] v);
    return (k == 1 && v[5]) ? int'(v) - 64 : int'(v);
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    bit tk;
    tk = m_cnt == int'(div);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < nch(k); c++) begin
        int o, t;
        o = m_out[k][c];
        t = m_tgt[k][c];
        if (tk) begin
          if (o < t) o += (int'(step_rise) < t - o) ? int'(step_rise) : t - o;
          else if (o > t) o -= (int'(step_fall) < o - t) ? int'(step_fall) : o - t;
          m_out[k][c] = o;
        end
        if (wr_en && int'(wr_ch) == c) m_tgt[k][c] = sx(k, wr_data);
      end
    m_cnt = tk ? 0 : (m_cnt + 1) % 256;
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      logic [23:0] ev, av;
      logic [3:0] es, as_;
      logic eb, ab;
      ev = '0;
      es = '0;
      eb = 1'b0;
      for (int c = 0; c < nch(k); c++) begin
        ev[c*6 +: 6] = 6'(m_out[k][c]);
        es[c] = m_out[k][c] == m_tgt[k][c];
        if (!es[c]) eb = 1'b1;
      end
      av = k == 0 ? do0 : k == 1 ? do1 : 24'(do2);
      as_ = k == 0 ? set0 : k == 1 ? set1 : 4'(set2);
      ab = k == 0 ? busy0 : k == 1 ? busy1 : busy2;
      chk($sformatf("dut%0d data_out", k), av, ev);
      chk($sformatf("dut%0d settled", k), 24'(as_), 24'(es));
      chk($sformatf("dut%0d busy", k), 24'(ab), 24'(eb));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    wr_en = 0;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        m_out[k][c] = 0;
        m_tgt[k][c] = 0;
      end
    m_cnt = 0;
    chk("reset async data", do0, 24'h0);
    chk("reset settled", 24'(set0), 24'hF);
    check_model();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int pe[3];
    int last, nchg, cur, prev;
    logic [5:0] pv;
    logic [5:0] sexp[4];
    pe = '{4, 8, 9};
    sexp = '{6'h00, 6'h3C, 6'h38, 6'h36};
    tbl[0] = '{1, 0, 32, 0, 4'hE};
    tbl[1] = '{0, 0, 0, 7, 4'hE};
    tbl[2] = '{0, 0, 0, 14, 4'hE};
    tbl[3] = '{0, 0, 0, 21, 4'hE};
    tbl[4] = '{0, 0, 0, 28, 4'hE};
    tbl[5] = '{0, 0, 0, 32, 4'hF};
    tbl[6] = '{1, 0, 15, 32, 4'hE};
    tbl[7] = '{0, 0, 0, 27, 4'hE};
    tbl[8] = '{0, 0, 0, 22, 4'hE};
    tbl[9] = '{0, 0, 0, 17, 4'hE};
    tbl[10] = '{0, 0, 0, 15, 4'hF};
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        m_out[k][c] = 0;
        m_tgt[k][c] = 0;
      end
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold reset data", do0, 24'h0);
    chk("hold reset busy", 24'(busy0), 24'h0);
    check_model();
    reset_n = 1;

    step_rise = 7;
    step_fall = 5;
    foreach (tbl[j]) begin
      wr_en = tbl[j].wr_en;
      wr_ch = tbl[j].wr_ch;
      wr_data = tbl[j].wr_data;
      cyc();
      chk($sformatf("tbl%0d ch0", j), 24'(do0[5:0]), 24'(tbl[j].exp0));
      chk($sformatf("tbl%0d settled", j), 24'(set0), 24'(tbl[j].exp_set));
    end
    wr_en = 0;

    do_reset();
    div = 3;
    step_rise = 4;
    wr_en = 1; wr_ch = 2; wr_data = 9;
    cyc();
    wr_en = 0;
    last = 0; nchg = 0; pv = 0;
    for (int t = 0; t < 40; t++) begin
      cyc();
      if (do0[17:12] != pv) begin
        pv = do0[17:12];
        if (nchg < 3) chk($sformatf("presc val%0d", nchg), 24'(pv), 24'(pe[nchg]));
        if (nchg > 0) chk("presc gap", 24'(t - last), 24'd4);
        last = t;
        nchg++;
      end
    end
    chk("presc change count", 24'(nchg), 24'd3);
    step_rise = 0;
    wr_en = 1; wr_ch = 2; wr_data = 20;
    cyc();
    wr_en = 0;
    for (int t = 0; t < 12; t++) begin
      cyc();
      chk("freeze ch2", 24'(do0[17:12]), 24'd9);
      chk("freeze busy", 24'(busy0), 24'd1);
    end

    div = 0;
    do_reset();
    step_rise = 7;
    step_fall = 5;
    wr_en = 1; wr_ch = 0; wr_data = 40;
    cyc();
    wr_en = 0;
    cyc();
    cyc();
    wr_en = 1; wr_data = 0;
    cyc();
    chk("tick-write old tgt", 24'(do0[5:0]), 24'd21);
    wr_en = 0;
    cyc();
    chk("tick-write new tgt", 24'(do0[5:0]), 24'd16);

    do_reset();
    step_fall = 4;
    wr_en = 1; wr_ch = 1; wr_data = 6'h36;
    for (int t = 0; t < 4; t++) begin
      cyc();
      wr_en = 0;
      chk($sformatf("signed fall %0d", t), 24'(do1[11:6]), 24'(sexp[t]));
    end
    step_fall = 7;
    wr_en = 1; wr_data = 6'h20;
    cyc();
    wr_en = 0;
    repeat (5) cyc();
    chk("signed at -32", 24'(do1[11:6]), 24'h20);
    step_rise = 7;
    wr_en = 1; wr_data = 6'h1F;
    prev = -32;
    for (int t = 0; t < 12; t++) begin
      cyc();
      wr_en = 0;
      cur = int'($signed(do1[11:6]));
      chk("signed rise monotonic", 24'(cur >= prev), 24'd1);
      prev = cur;
    end
    chk("signed reach 31", 24'(do1[11:6]), 24'h1F);

    do_reset();
    wr_en = 1; wr_ch = 3; wr_data = 50;
    cyc();
    wr_en = 0;
    repeat (3) cyc();
    chk("c3 ignore settled", 24'(set2), 24'h7);
    chk("c3 ignore data", 24'(do2), 24'h0);

    do_reset();
    step_rise = 1;
    wr_en = 1; wr_ch = 0; wr_data = 60;
    cyc();
    wr_en = 0;
    repeat (5) cyc();
    chk("mid-slew before reset", 24'(do0[5:0]), 24'd5);
    do_reset();

    for (int t = 0; t < 3000; t++) begin
      wr_en = ($urandom % 3) == 0;
      wr_ch = 2'($urandom);
      wr_data = 6'($urandom);
      step_rise = 3'($urandom);
      step_fall = 3'($urandom);
      if ($urandom % 50 == 0) div = 8'($urandom_range(0, 4));
      if ($urandom % 600 == 0) do_reset();
      else cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
